uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, clock_enable ticks per bit period; SHALL be even and >= 4.
REQ-002 CLKIN  input  1  sole clock; all state updates SHALL occur on its rising edge.
REQ-003 RESETN  input  1  reset, synchronous, active-low.
REQ-004 clock_enable  input  1  oversample tick; the receive FSM and counters SHALL advance only in cycles where it is 1.
REQ-005 rx  input  1  serial line, idle high; 8N1 frame, LSB first.
REQ-006 data  output  8  last accepted byte, registered.
REQ-007 valid  output  1  data holds an unconsumed byte.
REQ-008 ready  input  1  consumer accepts data in any cycle where valid && ready.
REQ-009 framing_error  output  1  one-CLKIN-cycle pulse on a bad stop bit.
REQ-010 overrun  output  1  sticky lost-byte flag; present only with UART_RX_OVERRUN_EN.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer clocked every CLKIN cycle; all sampling uses the synchronized value.
REQ-012 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: on a tick with synchronized rx==0 -> START, tick counter cleared.
REQ-014 START: after OVERSAMPLE/2 ticks (mid start bit), rx==0 -> DATA with bit index 0; rx==1 -> IDLE (glitch reject), with no output change.
REQ-015 DATA: every OVERSAMPLE ticks, sample rx into shift bit[index], LSB first; after bit 7 -> STOP.
REQ-016 STOP: after OVERSAMPLE ticks, rx==1 -> frame complete, IDLE; rx==0 -> framing_error pulse, byte discarded, BREAK.
REQ-017 BREAK: remain until a tick with rx==1, then IDLE.
REQ-018 Frame complete: data and valid SHALL update in the CLKIN cycle after the stop-sample tick.
REQ-019 Stop-bit midpoint SHALL fall on tick 8+9*OVERSAMPLE... specifically tick OVERSAMPLE/2 + 9*OVERSAMPLE after the start-detect tick.
REQ-020 valid && ready: valid SHALL clear the next cycle; this is evaluated every CLKIN cycle, independent of clock_enable.
REQ-021 Frame complete in the same cycle as valid && ready: the new byte SHALL load, valid stays 1, and there is no overrun.
REQ-022 Frame complete while valid==1 and ready==0: behaviour per REQ-027/REQ-028.
REQ-023 Counters: tick counter width clog2(OVERSAMPLE), wrap to 0 at OVERSAMPLE-1; bit index 3 bits.

Reset
REQ-024 RESETN==0 at a CLKIN edge: FSM -> IDLE, counters 0, synchronizer flops 1, data 0x00, valid 0, framing_error 0, overrun 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no valid or framing_error; reception resumes at the next falling rx after release.
REQ-026 Reset SHALL take priority over all other updates in the same cycle.

Configuration
REQ-027 Macro UART_RX_OVERRUN_EN defined: overrun port exists. A frame completing per REQ-022 SHALL be dropped, data retained, and overrun set to 1. overrun SHALL clear on reset or on the next valid && ready.
REQ-028 Macro UART_RX_OVERRUN_EN undefined: overrun port is absent. A frame completing per REQ-022 SHALL overwrite data, and valid stays 1.

Verification (OVERSAMPLE=16, clock_enable every cycle unless noted)
REQ-029 Frame 0xA5 on rx, ready=0 -> valid=1 and data=0xA5 one cycle after tick 152 from start detect; framing_error never 1.
REQ-030 rx low pulse of 4 ticks -> FSM returns to IDLE; valid, data, and framing_error are unchanged.
REQ-031 Frame 0x3C with stop bit 0 -> framing_error is a 1-cycle pulse, valid stays 0, and no new start is detected until rx is high again.
REQ-032 Frames 0x11 then 0x22, ready held 0 -> with macro: data=0x11, overrun=1, then ready=1 clears both overrun and valid; without macro: data=0x22, valid=1.
REQ-033 Frame completion coincident with ready=1 while holding 0x11, new byte 0x22 -> data=0x22, valid=1, overrun=0.
REQ-034 clock_enable every 3rd cycle, RESETN pulsed low during bit 4 of 0xFF -> all outputs are 0 the next cycle; a following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
//
// Oversampled 8N1 UART receiver (LSB first, idle-high line). The serial input
// is double-flopped into the CLKIN domain; the receive FSM and its counters
// advance only on clock_enable ticks, with OVERSAMPLE ticks per bit period.
// Each bit is sampled at its midpoint: the start bit OVERSAMPLE/2 ticks after
// the falling edge is seen, then every OVERSAMPLE ticks for data and stop.
// The stop-bit sample lands on tick OVERSAMPLE/2 + 9*OVERSAMPLE after the
// start-detect tick.
//
// Parameters
//   OVERSAMPLE     clock_enable ticks per bit period; must be even and >= 4.
//
// Ports
//   CLKIN          in   1  sole clock, rising edge.
//   RESETN         in   1  synchronous active-low reset.
//   clock_enable   in   1  oversample tick.
//   rx             in   1  asynchronous serial line, idle high.
//   data           out  8  last accepted byte (registered).
//   valid          out  1  data holds an unconsumed byte.
//   ready          in   1  consumer takes data in any cycle with valid && ready.
//   framing_error  out  1  one-CLKIN-cycle pulse on a low stop bit.
//   overrun        out  1  sticky lost-byte flag (only with UART_RX_OVERRUN_EN).
//
// Build option
//   UART_RX_OVERRUN_EN  defined: a byte completing while an unconsumed byte is
//                       held is dropped and overrun is set. Undefined: the new
//                       byte overwrites data and there is no overrun port.
// -----------------------------------------------------------------------------
module uart_receiver #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       CLKIN,
   input  logic       RESETN,
   input  logic       clock_enable,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       framing_error
`ifdef UART_RX_OVERRUN_EN
   ,
   output logic       overrun
`endif
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   state_t        r_state;
   logic [TW-1:0] r_tick;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_fe;
   logic [7:0]    r_data;
   logic          r_valid;
`ifdef UART_RX_OVERRUN_EN
   logic          r_overrun;
`endif

   logic w_frame_done;
   logic w_accept;

   // A good stop bit is seen on the stop-sample tick; r_shift is complete here.
   assign w_frame_done = clock_enable && (r_state == S_STOP) &&
                         (r_tick == FULL_M1) && r_sync2;
   assign w_accept     = r_valid && ready;

   // Synchronizer, receive FSM, bit counters and the framing-error pulse.
   // NOTE: every register here uses non-blocking assignment so all of them
   // update together from pre-edge values; blocking would let r_sync2 see the
   // new r_sync1 in the same edge and collapse the synchronizer to one flop.
   always_ff @(posedge CLKIN) begin
      if (!RESETN) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_state   <= S_IDLE;
         r_tick    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_fe      <= 1'b0;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         r_fe    <= 1'b0;

         if (clock_enable) begin
            unique case (r_state)
               S_IDLE: begin
                  if (!r_sync2) begin
                     r_state <= S_START;
                     r_tick  <= '0;
                  end
               end

               S_START: begin
                  if (r_tick == HALF_M1) begin
                     r_tick <= '0;
                     if (!r_sync2) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                     end else begin
                        // Line went high again before mid start bit: glitch.
                        r_state <= S_IDLE;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end

               S_DATA: begin
                  if (r_tick == FULL_M1) begin
                     r_tick             <= '0;
                     r_shift[r_bit_idx] <= r_sync2;
                     r_bit_idx          <= r_bit_idx + 3'd1;
                     if (r_bit_idx == 3'd7) begin
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end

               S_STOP: begin
                  if (r_tick == FULL_M1) begin
                     r_tick <= '0;
                     if (r_sync2) begin
                        r_state <= S_IDLE;
                     end else begin
                        r_fe    <= 1'b1;
                        r_state <= S_BREAK;
                     end
                  end else begin
                     r_tick <= r_tick + 1'b1;
                  end
               end

               S_BREAK: begin
                  // Wait out a held-low line so it cannot look like a start.
                  if (r_sync2) begin
                     r_state <= S_IDLE;
                  end
               end

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Output holding register and handshake; evaluated every CLKIN cycle so a
   // consumer is never throttled by clock_enable.
   always_ff @(posedge CLKIN) begin
      if (!RESETN) begin
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
         r_overrun <= 1'b0;
`endif
      end else if (w_frame_done) begin
`ifdef UART_RX_OVERRUN_EN
         if (r_valid && !ready) begin
            // Held byte still unconsumed: keep it, drop the new one.
            r_overrun <= 1'b1;
         end else begin
            r_data    <= r_shift;
            r_valid   <= 1'b1;
            r_overrun <= 1'b0;
         end
`else
         // Consumed or not, the newest byte wins and valid stays set.
         r_data  <= r_shift;
         r_valid <= 1'b1;
`endif
      end else if (w_accept) begin
         r_valid   <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
         r_overrun <= 1'b0;
`endif
      end
   end

   assign data          = r_data;
   assign valid         = r_valid;
   assign framing_error = r_fe;
`ifdef UART_RX_OVERRUN_EN
   assign overrun       = r_overrun;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
//
// Directed bench for uart_receiver at OVERSAMPLE=16. Inputs change and outputs
// are sampled on the falling clock edge. Frames are driven bit by bit from a
// task; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int OS = 16;

   logic       CLKIN;
   logic       RESETN;
   logic       clock_enable;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       framing_error;
`ifdef UART_RX_OVERRUN_EN
   logic       overrun;
`endif

   int total = 0;
   int bad   = 0;
   int fe_cnt = 0;
   int ce_div = 1;
   int ce_cnt = 0;

   uart_receiver #(.OVERSAMPLE(OS)) dut (
      .CLKIN         (CLKIN),
      .RESETN        (RESETN),
      .clock_enable  (clock_enable),
      .rx            (rx),
      .data          (data),
      .valid         (valid),
      .ready         (ready),
      .framing_error (framing_error)
`ifdef UART_RX_OVERRUN_EN
      ,
      .overrun       (overrun)
`endif
   );

   initial begin
      CLKIN = 1'b0;
      forever #5 CLKIN = ~CLKIN;
   end

   // clock_enable is high one cycle in every ce_div cycles.
   initial begin
      clock_enable = 1'b1;
      forever begin
         @(negedge CLKIN);
         clock_enable = (ce_cnt == 0);
         ce_cnt = (ce_cnt + 1 >= ce_div) ? 0 : ce_cnt + 1;
      end
   end

   // Cycles with framing_error high; a clean pulse adds exactly one.
   always @(negedge CLKIN) begin
      if (framing_error) fe_cnt = fe_cnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLKIN);
   endtask

   // Drive one frame starting at the current falling edge. per cycles per bit.
   // timing:   check valid exactly around the stop-sample tick (ce every cycle).
   // ready_at: pulse ready for one cycle at that frame cycle (-1 = never).
   // abort_at: pulse RESETN low at that frame cycle and abandon (-1 = never).
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input bit timing, input int ready_at,
                             input int abort_at);
      logic [9:0] bits;
      int per;
      bits = {stop_bit, b, 1'b0};
      per  = OS * ce_div;
      for (int c = 0; c < 10 * per; c++) begin
         if (c == abort_at) begin
            RESETN = 1'b0;
            rx     = 1'b1;
            @(negedge CLKIN);
            check("rst_data",  data,                  8'h00);
            check("rst_valid", {7'd0, valid},         8'h00);
            check("rst_fe",    {7'd0, framing_error}, 8'h00);
`ifdef UART_RX_OVERRUN_EN
            check("rst_ovr",   {7'd0, overrun},       8'h00);
`endif
            RESETN = 1'b1;
            return;
         end
         rx = bits[c / per];
         if (c == ready_at) ready = 1'b1;
         @(negedge CLKIN);
         if (c == ready_at) ready = 1'b0;
         // Start seen at posedge 3, stop sample 152 ticks later at posedge 155.
         if (timing && c == 153) check("valid_before_stop", {7'd0, valid}, 8'h00);
         if (timing && c == 154) begin
            check("valid_after_stop", {7'd0, valid}, 8'h01);
            check("data_after_stop",  data,          b);
         end
      end
      rx = 1'b1;
   endtask

   initial begin
      int fe_base;
      RESETN = 1'b0;
      rx     = 1'b1;
      ready  = 1'b0;

      // Reset state
      idle(3);
      check("reset_data",  data,                  8'h00);
      check("reset_valid", {7'd0, valid},         8'h00);
      check("reset_fe",    {7'd0, framing_error}, 8'h00);
`ifdef UART_RX_OVERRUN_EN
      check("reset_ovr",   {7'd0, overrun},       8'h00);
`endif
      RESETN = 1'b1;
      idle(5);

      // Frame 0xA5, exact completion timing
      send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
      idle(4);
      check("a5_data",  data,          8'hA5);
      check("a5_valid", {7'd0, valid}, 8'h01);
      check("a5_fe",    fe_cnt[7:0],   8'h00);

      // Short low glitch (4 ticks) is rejected
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(200);
      check("glitch_data",  data,          8'hA5);
      check("glitch_valid", {7'd0, valid}, 8'h01);
      check("glitch_fe",    fe_cnt[7:0],   8'h00);

      // Consume: valid clears the next cycle
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      check("consume_valid", {7'd0, valid}, 8'h00);
      idle(4);

      // Frame 0x3C with a low stop bit, line then held low (break)
      fe_base = fe_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
      rx = 1'b0;
      idle(300);
      check("break_fe_once", 8'(fe_cnt - fe_base), 8'h01);
      check("break_valid",   {7'd0, valid},         8'h00);
      rx = 1'b1;
      idle(300);
      check("break_end_fe",    8'(fe_cnt - fe_base), 8'h01);
      check("break_end_valid", {7'd0, valid},         8'h00);
      check("break_end_data",  data,                  8'hA5);

      // Back-to-back 0x11, 0x22 with ready held low
      send_frame(8'h11, 1'b1, 1'b0, -1, -1);
      idle(2);
      send_frame(8'h22, 1'b1, 1'b0, -1, -1);
      idle(4);
`ifdef UART_RX_OVERRUN_EN
      check("ovr_data",  data,            8'h11);
      check("ovr_flag",  {7'd0, overrun}, 8'h01);
      check("ovr_valid", {7'd0, valid},   8'h01);
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      check("ovr_clr_flag",  {7'd0, overrun}, 8'h00);
      check("ovr_clr_valid", {7'd0, valid},   8'h00);
`else
      check("ovw_data",  data,          8'h22);
      check("ovw_valid", {7'd0, valid}, 8'h01);
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      check("ovw_clr_valid", {7'd0, valid}, 8'h00);
`endif
      idle(4);

      // Completion coincident with ready while 0x11 is held
      send_frame(8'h11, 1'b1, 1'b0, -1, -1);
      idle(2);
      check("hold_11", data, 8'h11);
      send_frame(8'h22, 1'b1, 1'b0, 154, -1);
      idle(2);
      check("coinc_data",  data,          8'h22);
      check("coinc_valid", {7'd0, valid}, 8'h01);
`ifdef UART_RX_OVERRUN_EN
      check("coinc_ovr",   {7'd0, overrun}, 8'h00);
`endif
      ready = 1'b1;
      idle(1);
      ready = 1'b0;
      idle(4);

      // clock_enable every 3rd cycle; reset during data bit 4 of 0xFF
      ce_div = 3;
      idle(6);
      fe_base = fe_cnt;
      send_frame(8'hFF, 1'b1, 1'b0, -1, 5 * OS * 3 + OS * 3 / 2);
      idle(600);
      check("post_rst_valid", {7'd0, valid},         8'h00);
      check("post_rst_fe",    8'(fe_cnt - fe_base),  8'h00);

      send_frame(8'h5A, 1'b1, 1'b0, -1, -1);
      for (int i = 0; i < 300 && !valid; i++) @(negedge CLKIN);
      check("slow_valid", {7'd0, valid},        8'h01);
      check("slow_data",  data,                 8'h5A);
      check("slow_fe",    8'(fe_cnt - fe_base), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
